// File: rtl/traffic_phase_ctrl.sv
// Two-road (NS/EW) intersection phase sequencer.
// Phases run NS_G -> NS_Y -> AR1 -> EW_G -> EW_Y -> AR2 -> NS_G, each lasting its loaded
// duration in ticks. A latched pedestrian request cuts the current green short and stretches
// the next all-red into a walk interval. A flash override blinks both yellows.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   tick        one-cycle count enable (1 Hz)
//   ped_req     pedestrian button pulse
//   flash       level, 1 = flashing-yellow override
//   phase       0 NS_G, 1 NS_Y, 2 AR1, 3 EW_G, 4 EW_Y, 5 AR2, 6 FLASH
//   ns_light    NS lamps {red,yellow,green}, registered
//   ew_light    EW lamps {red,yellow,green}, registered
//   remain      ticks left in current phase, 0 in FLASH
//   ped_walk    walk lamp, registered
//   ped_pending pedestrian request latched, not yet served
module traffic_phase_ctrl #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned T_GREEN  = 9,
    parameter int unsigned T_YELLOW = 2,
    parameter int unsigned T_ALLRED = 1,
    parameter int unsigned T_WALK   = 5,
    parameter int unsigned PED_CUT  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             ped_req,
    input  logic             flash,
    output logic [2:0]       phase,
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic [WIDTH-1:0] remain,
    output logic             ped_walk,
    output logic             ped_pending
);

    typedef enum logic [2:0] {
        StNsG   = 3'd0,
        StNsY   = 3'd1,
        StAr1   = 3'd2,
        StEwG   = 3'd3,
        StEwY   = 3'd4,
        StAr2   = 3'd5,
        StFlash = 3'd6
    } phase_e;

    localparam logic [WIDTH-1:0] TGreen  = WIDTH'(T_GREEN);
    localparam logic [WIDTH-1:0] TYellow = WIDTH'(T_YELLOW);
    localparam logic [WIDTH-1:0] TAllred = WIDTH'(T_ALLRED);
    localparam logic [WIDTH-1:0] TWalk   = WIDTH'(T_WALK);
    localparam logic [WIDTH-1:0] PedCut  = WIDTH'(PED_CUT);
    localparam logic [WIDTH-1:0] One     = WIDTH'(1);

    localparam logic [2:0] LampRed    = 3'b100;
    localparam logic [2:0] LampYellow = 3'b010;
    localparam logic [2:0] LampGreen  = 3'b001;

    phase_e           phase_q, phase_d, ar_phase;
    logic [WIDTH-1:0] remain_q, remain_d;
    logic [2:0]       ns_q, ns_d, ew_q, ew_d;
    logic             walk_q, walk_d, pend_q, pend_d, blink_q, blink_d;
    logic             enter_ar;

    always_comb begin
        phase_d  = phase_q;
        remain_d = remain_q;
        walk_d   = walk_q;
        pend_d   = pend_q;
        blink_d  = blink_q;
        enter_ar = 1'b0;
        ar_phase = StAr2;

        if (flash) begin
            if (phase_q == StFlash) begin
                if (tick) blink_d = ~blink_q;
            end else begin
                phase_d  = StFlash;
                remain_d = '0;
                blink_d  = 1'b1;
                walk_d   = 1'b0;
            end
        end else begin
            case (phase_q)
                StFlash: begin
                    enter_ar = 1'b1;
                    ar_phase = StAr2;
                    blink_d  = 1'b0;
                end
                StNsG, StNsY, StAr1, StEwG, StEwY, StAr2: begin
                    if (tick) begin
                        // <= rather than == so a corrupted zero count still advances
                        if (remain_q <= One) begin
                            walk_d = 1'b0;
                            case (phase_q)
                                StNsG: begin phase_d = StNsY; remain_d = TYellow; end
                                StNsY: begin enter_ar = 1'b1; ar_phase = StAr1; end
                                StAr1: begin phase_d = StEwG; remain_d = TGreen;  end
                                StEwG: begin phase_d = StEwY; remain_d = TYellow; end
                                StEwY: begin enter_ar = 1'b1; ar_phase = StAr2; end
                                default: begin phase_d = StNsG; remain_d = TGreen; end
                            endcase
                        end else if ((phase_q == StNsG || phase_q == StEwG) && pend_q &&
                                     remain_q > PedCut) begin
                            remain_d = PedCut;
                        end else begin
                            remain_d = remain_q - One;
                        end
                    end
                end
                default: begin
                    phase_d  = StNsG;
                    remain_d = TGreen;
                    walk_d   = 1'b0;
                    blink_d  = 1'b0;
                end
            endcase

            if (enter_ar) begin
                phase_d = ar_phase;
                if (pend_q) begin
                    remain_d = TWalk;
                    walk_d   = 1'b1;
                    pend_d   = 1'b0;
                end else begin
                    remain_d = TAllred;
                    walk_d   = 1'b0;
                end
            end
        end

        // a new request overrides the clear from serving the previous one
        if (ped_req) pend_d = 1'b1;

        // lamps decoded from the next state so they change together with phase
        ns_d = LampRed;
        ew_d = LampRed;
        case (phase_d)
            StNsG:   ns_d = LampGreen;
            StNsY:   ns_d = LampYellow;
            StEwG:   ew_d = LampGreen;
            StEwY:   ew_d = LampYellow;
            StFlash: begin
                ns_d = {1'b0, blink_d, 1'b0};
                ew_d = {1'b0, blink_d, 1'b0};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= StNsG;
            remain_q <= TGreen;
            ns_q     <= LampGreen;
            ew_q     <= LampRed;
            walk_q   <= 1'b0;
            pend_q   <= 1'b0;
            blink_q  <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            remain_q <= remain_d;
            ns_q     <= ns_d;
            ew_q     <= ew_d;
            walk_q   <= walk_d;
            pend_q   <= pend_d;
            blink_q  <= blink_d;
        end
    end

    assign phase       = phase_q;
    assign remain      = remain_q;
    assign ns_light    = ns_q;
    assign ew_light    = ew_q;
    assign ped_walk    = walk_q;
    assign ped_pending = pend_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: a hand-derived vector table, a few directed
// multi-cycle sequences, then random stimulus checked against a behavioural model.
module tb_traffic_phase_ctrl;

    localparam int W   = 4;
    localparam int TG  = 9;
    localparam int TY  = 2;
    localparam int TAR = 1;
    localparam int TW  = 5;
    localparam int PC  = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tick = 1'b0;
    logic         ped_req = 1'b0;
    logic         flash = 1'b0;
    logic [2:0]   phase, ns_light, ew_light;
    logic [W-1:0] remain;
    logic         ped_walk, ped_pending;

    int n_checks = 0;
    int n_fail   = 0;

    traffic_phase_ctrl #(
        .WIDTH(W), .T_GREEN(TG), .T_YELLOW(TY), .T_ALLRED(TAR), .T_WALK(TW), .PED_CUT(PC)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req), .flash(flash),
        .phase(phase), .ns_light(ns_light), .ew_light(ew_light), .remain(remain),
        .ped_walk(ped_walk), .ped_pending(ped_pending)
    );

    always #5 clk = ~clk;

    // behavioural model: phase index 0..5 around the ring, 6 = flash
    int m_ph = 0, m_rem = TG;
    bit m_pend = 0, m_walk = 0, m_blink = 0;

    function automatic int dur(int p);
        case (p)
            0, 3:    return TG;
            1, 4:    return TY;
            default: return TAR;
        endcase
    endfunction

    function automatic logic [2:0] m_lamp(int ph, bit ew, bit blink);
        if (ph == 6) return {1'b0, blink, 1'b0};
        if (ph == (ew ? 3 : 0)) return 3'b001;
        if (ph == (ew ? 4 : 1)) return 3'b010;
        return 3'b100;
    endfunction

    task automatic enter_allred(int p);
        m_ph = p;
        if (m_pend) begin m_rem = TW; m_walk = 1; m_pend = 0; end
        else begin m_rem = TAR; m_walk = 0; end
    endtask

    task automatic model_step(bit r, bit t, bit p, bit f);
        int np;
        if (r) begin
            m_ph = 0; m_rem = TG; m_pend = 0; m_walk = 0; m_blink = 0;
            return;
        end
        if (f) begin
            if (m_ph == 6) begin
                if (t) m_blink = !m_blink;
            end else begin
                m_ph = 6; m_rem = 0; m_blink = 1; m_walk = 0;
            end
        end else if (m_ph == 6) begin
            m_blink = 0;
            enter_allred(5);
        end else if (t) begin
            if (m_rem == 1) begin
                m_walk = 0;
                np = (m_ph + 1) % 6;
                if (np == 2 || np == 5) enter_allred(np);
                else begin m_ph = np; m_rem = dur(np); end
            end else if ((m_ph == 0 || m_ph == 3) && m_pend && m_rem > PC) begin
                m_rem = PC;
            end else begin
                m_rem = m_rem - 1;
            end
        end
        if (p) m_pend = 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic chk_model();
        chk("phase",   32'(phase),       32'(m_ph));
        chk("remain",  32'(remain),      32'(m_rem));
        chk("ns",      32'(ns_light),    32'(m_lamp(m_ph, 0, m_blink)));
        chk("ew",      32'(ew_light),    32'(m_lamp(m_ph, 1, m_blink)));
        chk("walk",    32'(ped_walk),    32'(m_walk));
        chk("pending", 32'(ped_pending), 32'(m_pend));
    endtask

    // drive one clock with the given inputs; outputs sampled 1 ns after the edge
    task automatic apply(bit r, bit t, bit p, bit f);
        rst = r; tick = t; ped_req = p; flash = f;
        @(posedge clk);
        model_step(r, t, p, f);
        #1;
    endtask

    task automatic step(bit r, bit t, bit p, bit f);
        apply(r, t, p, f);
        chk_model();
    endtask

    task automatic advance_to(int ph, int rem);
        int n = 0;
        while (!(m_ph == ph && m_rem == rem) && n < 200) begin
            step(0, 1, 0, 0);
            n++;
        end
        if (n >= 200) chk("advance_timeout", 32'(n), 32'(0));
    endtask

    typedef struct {
        bit         r, t, p, f;
        int         ph, rem;
        logic [2:0] ns, ew;
        bit         walk, pend;
    } vec_t;

    vec_t vecs[23];

    initial begin
        vecs[0]  = '{1, 0, 0, 0, 0, 9, 3'b001, 3'b100, 0, 0};
        vecs[1]  = '{0, 1, 0, 0, 0, 8, 3'b001, 3'b100, 0, 0};
        vecs[2]  = '{0, 1, 0, 0, 0, 7, 3'b001, 3'b100, 0, 0};
        vecs[3]  = '{0, 0, 1, 0, 0, 7, 3'b001, 3'b100, 0, 1};
        vecs[4]  = '{0, 1, 0, 0, 0, 3, 3'b001, 3'b100, 0, 1};
        vecs[5]  = '{0, 1, 0, 0, 0, 2, 3'b001, 3'b100, 0, 1};
        vecs[6]  = '{0, 0, 0, 0, 0, 2, 3'b001, 3'b100, 0, 1};
        vecs[7]  = '{0, 1, 0, 0, 0, 1, 3'b001, 3'b100, 0, 1};
        vecs[8]  = '{0, 1, 0, 0, 1, 2, 3'b010, 3'b100, 0, 1};
        vecs[9]  = '{0, 1, 0, 0, 1, 1, 3'b010, 3'b100, 0, 1};
        vecs[10] = '{0, 1, 0, 0, 2, 5, 3'b100, 3'b100, 1, 0};
        vecs[11] = '{0, 1, 0, 0, 2, 4, 3'b100, 3'b100, 1, 0};
        vecs[12] = '{0, 1, 0, 0, 2, 3, 3'b100, 3'b100, 1, 0};
        vecs[13] = '{0, 1, 0, 0, 2, 2, 3'b100, 3'b100, 1, 0};
        vecs[14] = '{0, 1, 0, 0, 2, 1, 3'b100, 3'b100, 1, 0};
        vecs[15] = '{0, 1, 0, 0, 3, 9, 3'b100, 3'b001, 0, 0};
        vecs[16] = '{0, 0, 0, 1, 6, 0, 3'b010, 3'b010, 0, 0};
        vecs[17] = '{0, 1, 0, 1, 6, 0, 3'b000, 3'b000, 0, 0};
        vecs[18] = '{0, 0, 0, 1, 6, 0, 3'b000, 3'b000, 0, 0};
        vecs[19] = '{0, 1, 0, 1, 6, 0, 3'b010, 3'b010, 0, 0};
        vecs[20] = '{0, 0, 0, 0, 5, 1, 3'b100, 3'b100, 0, 0};
        vecs[21] = '{0, 1, 0, 0, 0, 9, 3'b001, 3'b100, 0, 0};
        vecs[22] = '{1, 0, 0, 0, 0, 9, 3'b001, 3'b100, 0, 0};

        // table-driven vectors
        for (int i = 0; i < 23; i++) begin
            apply(vecs[i].r, vecs[i].t, vecs[i].p, vecs[i].f);
            chk($sformatf("vec%0d_phase", i),   32'(phase),       32'(vecs[i].ph));
            chk($sformatf("vec%0d_remain", i),  32'(remain),      32'(vecs[i].rem));
            chk($sformatf("vec%0d_ns", i),      32'(ns_light),    32'(vecs[i].ns));
            chk($sformatf("vec%0d_ew", i),      32'(ew_light),    32'(vecs[i].ew));
            chk($sformatf("vec%0d_walk", i),    32'(ped_walk),    32'(vecs[i].walk));
            chk($sformatf("vec%0d_pending", i), 32'(ped_pending), 32'(vecs[i].pend));
        end

        // full cycle with ticks every 4 clocks
        step(0, 0, 0, 0);
        for (int i = 0; i < 24 * 4; i++) step(0, (i % 4) == 3, 0, 0);
        chk("cycle_back_phase", 32'(phase), 32'(0));
        chk("cycle_back_remain", 32'(remain), 32'(TG));

        // request late in green: no cut, walk still served at AR1
        advance_to(0, 2);
        step(0, 0, 1, 0);
        chk("nocut_hold", 32'(remain), 32'(2));
        step(0, 1, 0, 0);
        chk("nocut_dec", 32'(remain), 32'(1));
        advance_to(2, TW);
        chk("nocut_walk", 32'(ped_walk), 32'(1));
        chk("nocut_ar1_rem", 32'(remain), 32'(TW));

        // request on the same cycle as the all-red entry that serves the previous one
        advance_to(4, 2);
        step(0, 0, 1, 0);
        advance_to(4, 1);
        step(0, 1, 1, 0);
        chk("reserve_phase", 32'(phase), 32'(5));
        chk("reserve_walk", 32'(ped_walk), 32'(1));
        chk("reserve_pending", 32'(ped_pending), 32'(1));
        advance_to(0, TG);
        step(0, 1, 0, 0);
        chk("reserve_cut", 32'(remain), 32'(PC));
        advance_to(2, TW);
        chk("reserve_walk2", 32'(ped_walk), 32'(1));

        // reset mid EW_Y without tick, then frozen with no ticks
        advance_to(4, 2);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        chk("rst_phase", 32'(phase), 32'(0));
        chk("rst_remain", 32'(remain), 32'(TG));
        chk("rst_pending", 32'(ped_pending), 32'(0));
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);

        // random stimulus against the model
        begin
            bit f = 0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(59) == 0) f = !f;
                step($urandom_range(399) == 0, $urandom_range(2) == 0,
                     $urandom_range(9) == 0, f);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
